// File: rtl/arms_wb_checker.sv
// Writeback checker for the pipelined ARMS core: buffers expected per-instruction results,
// checks PC at issue and dselect/dbus LAT steps later. Define ARMS_WB_FLAGS_EN to add NZVC checking.
module arms_wb_checker #(
  parameter int unsigned DWIDTH = 64,
  parameter int unsigned AWIDTH = 64,
  parameter int unsigned SELW   = 32,
  parameter int unsigned LAT    = 4,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [AWIDTH-1:0] exp_pc,
  input  logic [SELW-1:0]   exp_dsel,
  input  logic [DWIDTH-1:0] exp_data,
  input  logic              exp_dsel_care,
  input  logic              exp_data_care,
`ifdef ARMS_WB_FLAGS_EN
  input  logic [3:0]        exp_nzvc,
  input  logic [3:0]        exp_nzvc_care,
  input  logic [3:0]        nzvc,
  output logic              flag_err,
`endif
  input  logic              run,
  input  logic [AWIDTH-1:0] iaddrbus,
  input  logic [SELW-1:0]   dselect,
  input  logic [DWIDTH-1:0] dbus,
  output logic              pc_err,
  output logic              sel_err,
  output logic              data_err,
  output logic [15:0]       err_count,
  output logic [15:0]       step_count,
  output logic [15:0]       first_err_idx,
  output logic              first_err_vld,
  output logic              underrun
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = PW + 1;

  typedef struct packed {
    logic [SELW-1:0]   dsel;
    logic [DWIDTH-1:0] data;
    logic              dsel_care;
    logic              data_care;
`ifdef ARMS_WB_FLAGS_EN
    logic [3:0]        nzvc;
    logic [3:0]        nzvc_care;
`endif
  } wb_t;

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    wb_t               wb;
  } entry_t;

  entry_t         fifo_mem [DEPTH];
  wb_t            pipe [LAT];
  logic [LAT-1:0] pipe_vld;
  logic [OW-1:0]  wr_ptr, rd_ptr, occ, occ_next;
  logic           full, empty, push, pop;
  entry_t         head, wr_entry;
  wb_t            tail;
  logic           wb_chk, pc_mis, sel_mis, data_mis, flag_mis, any_mis;
  logic [2:0]     err_inc;
  logic [16:0]    err_sum;

  // Occupancy uses the extra pointer bit so full and empty are distinguishable.
  always_comb begin
    occ      = wr_ptr - rd_ptr;
    full     = (occ == OW'(DEPTH));
    empty    = (occ == '0);
    push     = exp_valid & ~full;
    pop      = run & ~empty;
    occ_next = occ + OW'(push) - OW'(pop);
    head     = fifo_mem[rd_ptr[PW-1:0]];
  end

  always_comb begin
    wr_entry              = '0;
    wr_entry.pc           = exp_pc;
    wr_entry.wb.dsel      = exp_dsel;
    wr_entry.wb.data      = exp_data;
    wr_entry.wb.dsel_care = exp_dsel_care;
    wr_entry.wb.data_care = exp_data_care;
`ifdef ARMS_WB_FLAGS_EN
    wr_entry.wb.nzvc      = exp_nzvc;
    wr_entry.wb.nzvc_care = exp_nzvc_care;
`endif
  end

  // Case inequality so an X on a cared bus counts as a mismatch in simulation.
  always_comb begin
    tail     = pipe[LAT-1];
    wb_chk   = run & pipe_vld[LAT-1];
    pc_mis   = pop && (head.pc !== iaddrbus);
    sel_mis  = wb_chk && tail.dsel_care && (tail.dsel !== dselect);
    data_mis = wb_chk && tail.data_care && (tail.data !== dbus);
    flag_mis = 1'b0;
`ifdef ARMS_WB_FLAGS_EN
    flag_mis = wb_chk && ((nzvc & tail.nzvc_care) !== (tail.nzvc & tail.nzvc_care));
`endif
    any_mis  = pc_mis | sel_mis | data_mis | flag_mis;
    err_inc  = 3'(pc_mis) + 3'(sel_mis) + 3'(data_mis) + 3'(flag_mis);
    err_sum  = 17'(err_count) + 17'(err_inc);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      exp_ready     <= 1'b1;
      pipe_vld      <= '0;
      pc_err        <= 1'b0;
      sel_err       <= 1'b0;
      data_err      <= 1'b0;
`ifdef ARMS_WB_FLAGS_EN
      flag_err      <= 1'b0;
`endif
      err_count     <= '0;
      step_count    <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + OW'(1);
      if (pop)  rd_ptr <= rd_ptr + OW'(1);
      exp_ready <= (occ_next != OW'(DEPTH));
      pc_err    <= pc_mis;
      sel_err   <= sel_mis;
      data_err  <= data_mis;
`ifdef ARMS_WB_FLAGS_EN
      flag_err  <= flag_mis;
`endif
      if (run) begin
        for (int i = LAT - 1; i > 0; i--) pipe_vld[i] <= pipe_vld[i-1];
        pipe_vld[0] <= pop;
        step_count  <= step_count + 16'd1;
        err_count   <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        if (empty) underrun <= 1'b1;
        if (any_mis && !first_err_vld) begin
          first_err_vld <= 1'b1;
          first_err_idx <= step_count;
        end
      end
    end
  end

  // Payload storage needs no reset; validity lives in the pointers and pipe_vld.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= wr_entry;
    if (run) begin
      for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= head.wb;
    end
  end

endmodule

// File: tb/tb_arms_wb_checker.sv
// Directed bench for arms_wb_checker with a queue-based reference model and per-cycle scoreboard.
module tb_arms_wb_checker;
  localparam int unsigned DW = 64, AW = 64, SW = 32, LAT = 4, DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          exp_valid, exp_ready;
  logic [AW-1:0] exp_pc, iaddrbus;
  logic [SW-1:0] exp_dsel, dselect;
  logic [DW-1:0] exp_data, dbus;
  logic          exp_dsel_care, exp_data_care, run;
  logic          pc_err, sel_err, data_err, first_err_vld, underrun;
  logic [15:0]   err_count, step_count, first_err_idx;
`ifdef ARMS_WB_FLAGS_EN
  logic [3:0]    exp_nzvc, exp_nzvc_care, nzvc;
  logic          flag_err;
`endif

  always #5 clk = ~clk;

  arms_wb_checker #(.DWIDTH(DW), .AWIDTH(AW), .SELW(SW), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .exp_valid(exp_valid), .exp_ready(exp_ready),
    .exp_pc(exp_pc), .exp_dsel(exp_dsel), .exp_data(exp_data),
    .exp_dsel_care(exp_dsel_care), .exp_data_care(exp_data_care),
`ifdef ARMS_WB_FLAGS_EN
    .exp_nzvc(exp_nzvc), .exp_nzvc_care(exp_nzvc_care), .nzvc(nzvc), .flag_err(flag_err),
`endif
    .run(run), .iaddrbus(iaddrbus), .dselect(dselect), .dbus(dbus),
    .pc_err(pc_err), .sel_err(sel_err), .data_err(data_err), .err_count(err_count),
    .step_count(step_count), .first_err_idx(first_err_idx), .first_err_vld(first_err_vld),
    .underrun(underrun)
  );

  typedef struct {
    bit vld; logic [AW-1:0] pc; logic [SW-1:0] dsel; logic [DW-1:0] data;
    bit dc; bit tc; logic [3:0] nz; logic [3:0] nzc;
  } ent_t;

  typedef struct {
    bit pc_e; bit sel_e; bit data_e; bit flag_e; bit fv; bit un; bit rdy;
    logic [15:0] ec; logic [15:0] sc; logic [15:0] fi;
  } exp_t;

  ent_t        mq[$];
  ent_t        mp[$];
  exp_t        sb[$];
  ent_t        bub;
  logic [15:0] m_ec, m_sc, m_fi;
  bit          m_fv, m_un;
  int          n_checks = 0, n_errors = 0;
  logic [DW-1:0] xdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic ent_t mk(input logic [63:0] pc, input logic [31:0] dsel, input logic [63:0] data,
                              input bit dc, input bit tc, input logic [3:0] nz, input logic [3:0] nzc);
    ent_t e;
    e.vld = 1'b1; e.pc = pc; e.dsel = dsel; e.data = data;
    e.dc = dc; e.tc = tc; e.nz = nz; e.nzc = nzc;
    return e;
  endfunction

  task automatic m_reset();
    mq.delete(); mp.delete(); sb.delete();
    for (int i = 0; i < LAT; i++) mp.push_back(bub);
    m_ec = '0; m_sc = '0; m_fi = '0; m_fv = 1'b0; m_un = 1'b0;
  endtask

  // One clock: drive on the falling edge, model the step, compare after the rising edge.
  task automatic cyc(input bit pv, input ent_t e, input bit r, input logic [63:0] opc,
                     input logic [31:0] osel, input logic [63:0] odat, input logic [3:0] onz);
    exp_t x; ent_t h; ent_t w; int sum; bit full;
    @(negedge clk);
    exp_valid = pv; exp_pc = e.pc; exp_dsel = e.dsel; exp_data = e.data;
    exp_dsel_care = e.dc; exp_data_care = e.tc;
    run = r; iaddrbus = opc; dselect = osel; dbus = odat;
`ifdef ARMS_WB_FLAGS_EN
    exp_nzvc = e.nz; exp_nzvc_care = e.nzc; nzvc = onz;
`endif
    x = '{default: 0};
    h = bub;
    full = (mq.size() == DEPTH);
    if (r) begin
      if (mq.size() != 0) h = mq.pop_front();
      w = mp.pop_front();
      x.pc_e   = h.vld && (h.pc !== opc);
      x.sel_e  = w.vld && w.dc && (w.dsel !== osel);
      x.data_e = w.vld && w.tc && (w.data !== odat);
`ifdef ARMS_WB_FLAGS_EN
      x.flag_e = w.vld && ((onz & w.nzc) !== (w.nz & w.nzc));
`endif
      mp.push_back(h);
      sum = int'(x.pc_e) + int'(x.sel_e) + int'(x.data_e) + int'(x.flag_e);
      if (sum != 0 && !m_fv) begin m_fv = 1'b1; m_fi = m_sc; end
      m_ec = (int'(m_ec) + sum > 65535) ? 16'hFFFF : 16'(int'(m_ec) + sum);
      m_sc = m_sc + 16'd1;
      if (!h.vld) m_un = 1'b1;
    end
    if (pv && !full) begin e.vld = 1'b1; mq.push_back(e); end
    x.ec = m_ec; x.sc = m_sc; x.fi = m_fi; x.fv = m_fv; x.un = m_un;
    x.rdy = (mq.size() != DEPTH);
    sb.push_back(x);
    @(posedge clk); #1;
    x = sb.pop_front();
    chk("pc_err", 64'(pc_err), 64'(x.pc_e));
    chk("sel_err", 64'(sel_err), 64'(x.sel_e));
    chk("data_err", 64'(data_err), 64'(x.data_e));
`ifdef ARMS_WB_FLAGS_EN
    chk("flag_err", 64'(flag_err), 64'(x.flag_e));
`endif
    chk("err_count", 64'(err_count), 64'(x.ec));
    chk("step_count", 64'(step_count), 64'(x.sc));
    chk("underrun", 64'(underrun), 64'(x.un));
    chk("exp_ready", 64'(exp_ready), 64'(x.rdy));
    chk("first_err_vld", 64'(first_err_vld), 64'(x.fv));
    if (x.fv) chk("first_err_idx", 64'(first_err_idx), 64'(x.fi));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; exp_valid = 1'b0; run = 1'b0;
    m_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // 24-instruction straight-line program; 'bad' selects an entry whose dbus is corrupted.
  task automatic run_program(input int bad);
    ent_t prog[24];
    int pi;
    logic [63:0] opc, odat;
    logic [31:0] osel;
    for (int k = 0; k < 24; k++)
      prog[k] = mk(64'(4 * k), 32'h1 << ((20 + k) % 32), 64'h1000 + 64'(k), 1'b1, 1'b1, 4'h0, 4'h0);
    prog[0].data = 64'hAAA;
    prog[6].data = 64'hAA0;
    for (int k = 0; k < 4; k++) cyc(1'b1, prog[k], 1'b0, '0, '0, '0, 4'h0);
    pi = 4;
    for (int s = 0; s < 28; s++) begin
      opc  = (s < 24) ? prog[s].pc : 64'hBAD0;
      osel = (s >= 4) ? prog[s-4].dsel : '0;
      odat = (s >= 4) ? prog[s-4].data : '0;
      if (s - 4 == bad) odat = odat ^ 64'h1;
      cyc(pi < 24, prog[(pi < 24) ? pi : 0], 1'b1, opc, osel, odat, 4'h0);
      if (pi < 24) pi++;
      if (bad >= 0 && s == bad + 4) chk("corrupt_pulse", 64'(data_err), 64'd1);
    end
  endtask

  initial begin
    bub = '{default: 0};
    xdata = 'x;
    reset = 1'b0; exp_valid = 1'b0; run = 1'b0;
    exp_pc = '0; exp_dsel = '0; exp_data = '0; exp_dsel_care = 1'b0; exp_data_care = 1'b0;
    iaddrbus = '0; dselect = '0; dbus = '0;
`ifdef ARMS_WB_FLAGS_EN
    exp_nzvc = '0; exp_nzvc_care = '0; nzvc = '0;
`endif
    m_reset();
    repeat (2) @(negedge clk);
    chk("reset_exp_ready", 64'(exp_ready), 64'd1);
    chk("reset_err_count", 64'(err_count), 64'd0);
    chk("reset_step_count", 64'(step_count), 64'd0);
    chk("reset_underrun", 64'(underrun), 64'd0);
    reset = 1'b1;

    // Reset mid-run after two PC mismatches
    for (int i = 0; i < 3; i++)
      cyc(1'b1, mk(64'h10 + 64'(4 * i), 32'h1, 64'h77, 1'b1, 1'b1, 4'h0, 4'h0), 1'b0, '0, '0, '0, 4'h0);
    cyc(1'b0, bub, 1'b1, 64'hFFFF, '0, '0, 4'h0);
    cyc(1'b0, bub, 1'b1, 64'hFFFF, '0, '0, 4'h0);
    chk("prerst_err_count", 64'(err_count), 64'd2);
    @(negedge clk);
    reset = 1'b0; run = 1'b0; exp_valid = 1'b0;
    #1;
    chk("rst_exp_ready", 64'(exp_ready), 64'd1);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    chk("rst_step_count", 64'(step_count), 64'd0);
    chk("rst_pc_err", 64'(pc_err), 64'd0);
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rel_exp_ready", 64'(exp_ready), 64'd1);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, mk(64'h20 + 64'(4 * i), 32'h1, 64'h5, 1'b1, 1'b1, 4'h0, 4'h0), 1'b0, '0, '0, '0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, bub, 1'b1, 64'h20 + 64'(4 * i), 32'hFFFF_FFFF, 64'hFFFF, 4'h0);
      chk("post_rst_no_pulse", 64'({pc_err, sel_err, data_err}), 64'd0);
    end

    // Clean straight-line program
    do_reset();
    run_program(-1);
    chk("clean_err_count", 64'(err_count), 64'd0);
    chk("clean_first_vld", 64'(first_err_vld), 64'd0);

    // Corrupted dbus on entry 6
    do_reset();
    run_program(6);
    chk("corrupt_err_count", 64'(err_count), 64'd1);
    chk("corrupt_first_idx", 64'(first_err_idx), 64'd10);
    chk("corrupt_first_vld", 64'(first_err_vld), 64'd1);

    // Don't-care vs cared X on dbus
    do_reset();
    cyc(1'b1, mk(64'h40, 32'h0, 64'h55, 1'b0, 1'b0, 4'h0, 4'h0), 1'b0, '0, '0, '0, 4'h0);
    cyc(1'b1, mk(64'h44, 32'h0, 64'h123, 1'b0, 1'b1, 4'h0, 4'h0), 1'b0, '0, '0, '0, 4'h0);
    for (int s = 0; s < 6; s++) begin
      cyc(1'b0, bub, 1'b1, (s == 0) ? 64'h40 : ((s == 1) ? 64'h44 : 64'h0), '0,
          (s >= 4) ? xdata : 64'h0, 4'h0);
      if (s == 4) chk("dc_x_no_err", 64'(data_err), 64'd0);
      if (s == 5) chk("care_x_err", 64'(data_err), 64'd1);
    end
    chk("x_err_count", 64'(err_count), 64'd1);

    // FIFO full / refused push / underrun
    do_reset();
    for (int i = 0; i < 8; i++)
      cyc(1'b1, mk(64'h100 + 64'(4 * i), '0, '0, 1'b0, 1'b0, 4'h0, 4'h0), 1'b0, '0, '0, '0, 4'h0);
    chk("full_exp_ready", 64'(exp_ready), 64'd0);
    cyc(1'b1, mk(64'hDEAD, '0, '0, 1'b0, 1'b0, 4'h0, 4'h0), 1'b0, '0, '0, '0, 4'h0);
    chk("ninth_refused", 64'(exp_ready), 64'd0);
    cyc(1'b1, mk(64'hBEEF, '0, '0, 1'b0, 1'b0, 4'h0, 4'h0), 1'b1, 64'h100, '0, '0, 4'h0);
    chk("push_pop_full_ready", 64'(exp_ready), 64'd1);
    for (int i = 1; i < 8; i++) cyc(1'b0, bub, 1'b1, 64'h100 + 64'(4 * i), '0, '0, 4'h0);
    chk("drained_no_underrun", 64'(underrun), 64'd0);
    cyc(1'b0, bub, 1'b1, 64'h5555, '0, '0, 4'h0);
    chk("empty_underrun", 64'(underrun), 64'd1);
    chk("empty_no_pc_err", 64'(pc_err), 64'd0);

`ifdef ARMS_WB_FLAGS_EN
    // SUBIS R20,R0,#3: expected N set, observed flags clear
    do_reset();
    cyc(1'b1, mk(64'h0, 32'h0010_0000, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 4'b1000, 4'b1111),
        1'b0, '0, '0, '0, 4'h0);
    for (int s = 0; s < 5; s++) begin
      cyc(1'b0, bub, 1'b1, 64'h0, '0, '0, 4'b0000);
      if (s == 4) chk("flag_pulse", 64'(flag_err), 64'd1);
    end
    chk("flag_err_count", 64'(err_count), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/arms_wb_checker.md
# arms_wb_checker

Synthesizable, parametrised writeback checker for the pipelined ARMS core. It buffers expected per-instruction results (PC, dselect, dbus) in a FIFO and compares them cycle by cycle against the live core buses. PC is checked on issue, and dselect/dbus are checked LAT instructions later, when that instruction writes back. It sits beside `ARMS` in simulation and FPGA bring-up, replaces hand-written per-test compare loops, and reports error counts and first-failure index.

## Interface
- DWIDTH, 64, data width of dbus and expected data
- AWIDTH, 64, width of iaddrbus and expected PC
- SELW, 32, width of one-hot dselect
- LAT, 4, issue-to-writeback distance in instructions (1..8)
- DEPTH, 8, expected-entry FIFO depth (power of two, ≥2)
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  one clock; reset is asynchronous and active-low
- exp_valid  in  1  expected entry offered
- exp_ready  out  1  FIFO can accept; equals !full
- exp_pc  in  AWIDTH  expected iaddrbus at issue
- exp_dsel  in  SELW  expected dselect at writeback
- exp_data  in  DWIDTH  expected dbus at writeback
- exp_dsel_care / exp_data_care  in  1 each  0 = don't-care for that field
- run  in  1  one instruction step per cycle while high
- iaddrbus  in  AWIDTH  observed PC
- dselect  in  SELW  observed writeback select
- dbus  in  DWIDTH  observed writeback data
- pc_err / sel_err / data_err  out  1 each  one-cycle mismatch pulses
- err_count  out  16  saturating total mismatches
- step_count  out  16  run cycles executed, wraps
- first_err_idx  out  16  step_count value of first mismatch; valid when first_err_vld
- first_err_vld  out  1  sticky
- underrun  out  1  sticky; run with FIFO empty

## Operation
- Push: exp_valid & exp_ready writes the entry at the tail. Push while full is refused, even if a pop occurs in the same cycle.
- Step (run=1): pop the head entry and compare exp_pc to iaddrbus (pc check); shift the entry into a LAT-stage pipe; step_count increments.
- Writeback check: the entry leaving pipe stage LAT is compared on the same step. dselect is compared if dsel_care=1, dbus if data_care=1. Comparison uses 4-state inequality in simulation (X on a cared bus = mismatch).
- Empty FIFO on a step: a bubble enters the pipe, no pc check is made, and underrun is set. Bubbles exiting the pipe are never checked.
- run=0: pipe, FIFO head and counters hold; the pipe does not advance.
- err_count adds pc_err+sel_err+data_err (0..3) per step and saturates at 16'hFFFF.
- The first step with any mismatch latches first_err_idx = step_count (pre-increment) and sets first_err_vld.
- Reset (async, active-low, may occur mid-run): FIFO empty, pipe filled with bubbles, all counters/flags/pulses 0, exp_ready=1 one cycle after deassertion.

## Timing
- Observed buses are sampled at the rising edge where run=1. The core's buses must be stable before that edge; the bench drives the core on the falling edge.
- Error pulses and counters update at that same edge and are visible for exactly one cycle (pulses) or until the next step.
- Push-to-first-possible-pop latency: 1 cycle (an entry pushed at edge N can be popped at edge N+1).
- Simultaneous push and pop when not full: both occur, and occupancy is unchanged.
- Pointer wrap at DEPTH is handled by an extra occupancy bit. full = occupancy==DEPTH, empty = occupancy==0.
- Writeback check for issue step k occurs at step k+LAT. The first LAT steps after reset check nothing.

## Configuration
- ARMS_WB_FLAGS_EN defined: adds input `nzvc` [3:0], per-entry `exp_nzvc` [3:0] and `exp_nzvc_care` [3:0] (bitwise don't-care), and output `flag_err`. Flags are checked at writeback alongside dbus and count toward err_count and first_err.
- Undefined: these ports do not exist, no flag storage is allocated, and err_count adds at most 3 per step.

## Test plan
- Reset mid-run: push 3 entries, step twice, assert reset low → exp_ready=1, err_count=0, underrun=0, pipe bubbles, and no pulse on the next 4 steps.
- Straight-line program: push 24 entries with PC 0x00,0x04…0x5C and ADDI R20 result 0xAAA (dsel 0x0010_0000) at entry 0; the DUT matches → err_count=0, and the entry-0 data check fires at step 4.
- Corrupt dbus of entry 6 (0xAA0 observed as 0xAA1) → data_err pulse at step 10, err_count=1, first_err_idx=10.
- Don't-care: entries with care=0 and an X-driven dbus → no error. With care=1, X → data_err.
- FIFO boundary: DEPTH=8, push 8 with run=0 → exp_ready=0; a 9th push is refused; a push plus step on the same cycle while full → occupancy 7. Stepping with the FIFO empty → underrun=1, no pc_err.
- With ARMS_WB_FLAGS_EN: SUBIS R20,R0,#3 expected nzvc=1000, observed 0000 → flag_err at its writeback step, err_count=1.
